if_stage: RTL and testbench

Instruction-fetch stage of the MIPS core: owns the PC, issues one-outstanding word fetches to instruction memory over a valid/ready request and valid-only response, and presents the fetched word with its PC in an IF/ID register. The decoder reads `id_op_code` from this register. Branch/jump resolution redirects it, discarding wrong-path fetches. It also supplies `id_pc_plus4` for the JAL link write.

---
 rtl/if_pkg.sv | 27 ++
 rtl/if_skid_buf.sv | 41 ++++
 rtl/if_stage.sv | 153 +++++++++++++++
 tb/tb_if_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int OP_FIELD_HI = 31;
  localparam int OP_FIELD_LO = 26;
  localparam logic [31:0] PC_STEP = 32'd4;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } if_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [31:0]            pc;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding buffer for a fetched {instr, pc} that cannot enter IF/ID yet.
module if_skid_buf
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_unload,
  input  fetch_entry_t i_entry,
  output logic         o_full,
  output fetch_entry_t o_entry
);

  logic         r_full;
  fetch_entry_t r_entry;

  // Occupancy: clear dominates; a load in the same cycle as an unload refills the slot.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  // Payload capture; contents are only meaningful while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry <= '0;
    end else if (i_load && !i_clear) begin
      r_entry <= i_entry;
    end
  end

  assign o_full  = r_full;
  assign o_entry = r_entry;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding IMem fetch sequencer and IF/ID register.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  output logic [31:0]            imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   id_stall,
  output logic                   id_valid,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [5:0]             id_op_code,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_pc_plus4
);

  if_state_t              r_state;
  if_state_t              w_state_next;
  logic [31:0]            r_pc;
  logic [31:0]            r_fetch_pc;
  logic                   r_id_valid;
  logic [INSTR_WIDTH-1:0] r_id_instr;
  logic [31:0]            r_id_pc;

  logic                   w_req_valid;
  logic                   w_req_fire;
  logic                   w_rsp_take;
  logic                   w_id_advance;
  logic                   w_fetch_outstanding;
  logic                   w_skid_full;
  logic                   w_skid_load;
  logic                   w_skid_unload;
  fetch_entry_t           w_skid_out;
  fetch_entry_t           w_rsp_entry;

  // A request is only offered when a returning word is guaranteed a place to land.
  assign w_req_valid  = !rst && (r_state == REQ) && !w_skid_full;
  assign w_req_fire   = w_req_valid && imem_req_ready;
  // Responses are only kept in WAIT, and never in a redirect cycle.
  assign w_rsp_take   = (r_state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_id_advance = !r_id_valid || !id_stall;
  assign w_rsp_entry  = {imem_rsp_data, r_fetch_pc};

  // A fetch is still in flight after this cycle if one was just accepted, or one was
  // already pending and its response did not arrive now.
  assign w_fetch_outstanding = ((r_state == REQ) && w_req_fire) ||
                               (((r_state == WAIT) || (r_state == DROP)) && !imem_rsp_valid);

  // The buffer drains into IF/ID first; a new word goes to the buffer unless it can enter IF/ID directly.
  assign w_skid_unload = w_id_advance && w_skid_full && !redirect_valid;
  assign w_skid_load   = w_rsp_take && !(w_id_advance && !w_skid_full);

  if_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (redirect_valid),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_entry  (w_rsp_entry),
    .o_full   (w_skid_full),
    .o_entry  (w_skid_out)
  );

  // Next-state selection; a redirect overrides normal sequencing.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = w_fetch_outstanding ? DROP : REQ;
    end else begin
      case (r_state)
        REQ: begin
          if (w_req_fire) begin
            w_state_next = WAIT;
          end
        end
        WAIT, DROP: begin
          if (imem_rsp_valid) begin
            w_state_next = REQ;
          end
        end
        default: w_state_next = REQ;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Program counter: redirect target wins, otherwise step on every accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= word_align(redirect_pc);
    end else if (w_req_fire) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  // Remember which address the outstanding fetch belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= '0;
    end else if (w_req_fire) begin
      r_fetch_pc <= r_pc;
    end
  end

  // IF/ID register: flush on redirect, hold on stall, otherwise load buffer, new word, or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else if (redirect_valid) begin
      r_id_valid <= 1'b0;
    end else if (w_id_advance) begin
      if (w_skid_full) begin
        r_id_valid <= 1'b1;
        r_id_instr <= w_skid_out.instr;
        r_id_pc    <= w_skid_out.pc;
      end else if (w_rsp_take) begin
        r_id_valid <= 1'b1;
        r_id_instr <= imem_rsp_data;
        r_id_pc    <= r_fetch_pc;
      end else begin
        r_id_valid <= 1'b0;
      end
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign id_valid       = r_id_valid;
  assign id_instr       = r_id_instr;
  assign id_op_code     = r_id_instr[OP_FIELD_HI:OP_FIELD_LO];
  assign id_pc          = r_id_pc;
  assign id_pc_plus4    = r_id_pc + PC_STEP;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: an IMem model plus an in-order expected instruction stream.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [5:0]  id_op_code;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_op_code     (id_op_code),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          n_consume = 0;
  bit          mon_en    = 0;

  // IMem model state
  bit          busy      = 0;
  int          wait_cnt  = 0;
  int          lat_mode  = 1;
  logic [31:0] rsp_addr  = '0;
  logic [31:0] path_pc   = 32'h0000_3000;

  // Values seen just before each rising edge
  bit          s_hs = 0, s_rsp_v = 0, s_redirect = 0;
  logic [31:0] s_addr = '0, s_target = '0;
  bit          p_bp = 0, p_hold = 0, p_redir = 0;
  logic [31:0] p_addr = '0, p_instr = '0, p_pc = '0, p_target = '0;
  exp_t        mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; update IMem model and the expected stream from the edge just taken.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (s_rsp_v) busy = 0;
    if (s_hs) begin
      chk("req_addr", s_addr, path_pc);
      chk("one_outstanding", {31'd0, busy}, 32'd0);
      busy     = 1;
      rsp_addr = s_addr;
      wait_cnt = ((lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode) - 1;
      if (!s_redirect) begin
        e.pc    = path_pc;
        e.instr = mem_word(path_pc);
        sb_q.push_back(e);
        path_pc = path_pc + 32'd4;
      end
    end
    if (s_redirect) begin
      sb_q.delete();
      path_pc = s_target & ~32'h3;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (busy) begin
      if (wait_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(rsp_addr);
      end else begin
        wait_cnt--;
      end
    end
  endtask

  // Monitor: checks cycle-to-cycle rules and pops the scoreboard on every consumed word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (p_redir) begin
        chk("redirect_flush", {31'd0, id_valid}, 32'd0);
        chk("redirect_addr", imem_req_addr, p_target & ~32'h3);
      end
      if (p_hold) begin
        chk("stall_valid", {31'd0, id_valid}, 32'd1);
        chk("stall_instr", id_instr, p_instr);
        chk("stall_pc", id_pc, p_pc);
      end
      if (p_bp) begin
        chk("bp_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("bp_addr", imem_req_addr, p_addr);
      end
      chk("occupancy_le2", {31'd0, sb_q.size() <= 2}, 32'd1);
      if (id_valid && !id_stall && !redirect_valid) begin
        n_consume++;
        chk("word_expected", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          $display("word pc=%h instr=%h op=%b", id_pc, id_instr, id_op_code);
          chk("id_pc", id_pc, mon_e.pc);
          chk("id_instr", id_instr, mon_e.instr);
          chk("id_op_code", {26'd0, id_op_code}, {26'd0, mon_e.instr[31:26]});
          chk("id_pc_plus4", id_pc_plus4, mon_e.pc + 32'd4);
        end
      end
    end
    s_hs       = imem_req_valid && imem_req_ready;
    s_addr     = imem_req_addr;
    s_rsp_v    = imem_rsp_valid;
    s_redirect = redirect_valid;
    s_target   = redirect_pc;
    p_redir    = !rst && redirect_valid;
    p_target   = redirect_pc;
    p_hold     = !rst && id_stall && id_valid && !redirect_valid;
    p_instr    = id_instr;
    p_pc       = id_pc;
    p_bp       = !rst && imem_req_valid && !imem_req_ready && !redirect_valid;
    p_addr     = imem_req_addr;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc0;
    rst = 1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; id_stall = 0;

    // Reset
    repeat (3) begin
      step();
      chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    rst = 0; imem_req_ready = 1; mon_en = 1; lat_mode = 1;
    #1;
    chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("reset_req_addr", imem_req_addr, 32'h0000_3000);

    // Best-case timing: accept, respond, present
    step();
    step();
    chk("first_valid", {31'd0, id_valid}, 32'd1);
    chk("first_pc", id_pc, 32'h0000_3000);
    chk("first_plus4", id_pc_plus4, 32'h0000_3004);
    chk("first_op", {26'd0, id_op_code}, {26'd0, 6'b100011});
    chk("second_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("second_req_addr", imem_req_addr, 32'h0000_3004);

    // Backpressure
    imem_req_ready = 0;
    repeat (5) begin
      step();
      chk("bp_hold_addr", imem_req_addr, 32'h0000_3004);
      chk("bp_hold_valid", {31'd0, imem_req_valid}, 32'd1);
    end
    imem_req_ready = 1;

    // Stall with one word buffered
    for (int k = 0; k < 20 && id_valid !== 1'b1; k++) step();
    chk("wait_valid_stall", {31'd0, id_valid}, 32'd1);
    id_stall = 1;
    repeat (6) step();
    chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
    pc0 = id_pc;
    id_stall = 0;
    step();
    chk("unstall_valid", {31'd0, id_valid}, 32'd1);
    chk("unstall_pc", id_pc, pc0 + 32'd4);

    // Redirect while waiting for a response
    lat_mode = 3;
    for (int k = 0; k < 20 && !(busy && !imem_rsp_valid); k++) step();
    chk("wait_busy", {31'd0, busy && !imem_rsp_valid}, 32'd1);
    redirect_valid = 1; redirect_pc = 32'h0000_4002;
    step();
    redirect_valid = 0;
    chk("redir_wait_addr", imem_req_addr, 32'h0000_4000);
    for (int k = 0; k < 30 && id_valid !== 1'b1; k++) step();
    chk("redir_first_pc", id_pc, 32'h0000_4000);

    // Redirect during stall with the buffer full
    lat_mode = 1; id_stall = 1;
    for (int k = 0; k < 20 && !(id_valid && !imem_req_valid && !busy); k++) step();
    chk("wait_buf_full", {31'd0, id_valid && !imem_req_valid && !busy}, 32'd1);
    redirect_valid = 1; redirect_pc = 32'h0000_5000;
    step();
    redirect_valid = 0;
    chk("redir_stall_flush", {31'd0, id_valid}, 32'd0);
    chk("redir_buf_empty", {31'd0, imem_req_valid}, 32'd1);
    id_stall = 0;

    // Redirect in the same cycle as a response
    lat_mode = 2;
    for (int k = 0; k < 20 && imem_rsp_valid !== 1'b1; k++) step();
    chk("wait_rsp", {31'd0, imem_rsp_valid}, 32'd1);
    redirect_valid = 1; redirect_pc = 32'h0000_6000;
    step();
    redirect_valid = 0;
    chk("rsp_redirect_drop", {31'd0, id_valid}, 32'd0);
    for (int k = 0; k < 20 && id_valid !== 1'b1; k++) step();
    chk("after_drop_pc", id_pc, 32'h0000_6000);

    // PC wrap
    lat_mode = 1;
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 0;
    for (int k = 0; k < 30 && !(id_valid && id_pc == 32'hFFFF_FFFC); k++) step();
    chk("wrap_top_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", id_pc_plus4, 32'h0000_0000);
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    for (int k = 0; k < 10 && !(id_valid && id_pc == 32'h0000_0000); k++) step();
    chk("wrap_zero_pc", id_pc, 32'h0000_0000);
    chk("wrap_zero_plus4", id_pc_plus4, 32'h0000_0004);

    // Randomized traffic
    lat_mode = 0;
    for (int c = 0; c < 1500; c++) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      id_stall       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 49) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step();
    end

    // Drain and confirm forward progress
    imem_req_ready = 1; id_stall = 0; redirect_valid = 0;
    repeat (20) step();
    chk("progress", {31'd0, n_consume > 100}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
